// File: rtl/ntt_sched_if.sv
// Issue bus between the NTT sequencer and the butterfly pipeline / controller.
// The sequencer side takes the master view; the consumer side takes the slave view.
interface ntt_sched_if;
  logic       start;
  logic       mode;
  logic       stall;
  logic       busy;
  logic       done;
  logic       o_v;
  logic       o_last;
  logic       o_done;
  logic       o_sel;
  logic [7:0] addr_up;
  logic [7:0] addr_dn;
  logic [6:0] zeta_idx;
  logic [2:0] layer;

  modport master (
    input  start, mode, stall,
    output busy, done, o_v, o_last, o_done, o_sel,
    output addr_up, addr_dn, zeta_idx, layer
  );

  modport slave (
    output start, mode, stall,
    input  busy, done, o_v, o_last, o_done, o_sel,
    input  addr_up, addr_dn, zeta_idx, layer
  );
endinterface

// File: rtl/ntt_sched.sv
// ntt_sched: issue sequencer for a 256-point Kyber NTT/INTT butterfly pipeline.
// Seven layers of 128 butterflies, one per cycle, with a fixed drain gap after
// each layer so reads of the next layer never overtake write-backs of this one.
// Every output is a register loaded from the state of the previous cycle.
module ntt_sched #(
  parameter int DRAIN = 8
) (
  input  logic        clk,
  input  logic        rst,
  ntt_sched_if.master io_sched
);

  localparam int         N          = 256;
  localparam logic [6:0] LAST_BF    = 7'(N / 2 - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);
  localparam logic [2:0] LAST_LAYER = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_bf;
  logic [6:0] w_bf_nxt;
  logic [2:0] r_layer;
  logic [2:0] w_layer_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_sel;
  logic       w_sel_nxt;
  logic       w_issue;

  logic       r_busy;
  logic       r_done;
  logic       r_v;
  logic       r_last;
  logic       r_fin;
  logic [7:0] r_addr_up;
  logic [7:0] r_addr_dn;
  logic [6:0] r_zeta;
  logic [2:0] r_layer_o;

  logic [2:0] w_lg;
  logic [7:0] w_len;
  logic [7:0] w_g;
  logic [7:0] w_o;
  logic [7:0] w_up;
  logic [7:0] w_dn;
  logic [6:0] w_zeta;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and counter update; a butterfly issues only in ISSUE without stall.
  always_comb begin
    w_state_nxt = r_state;
    w_bf_nxt    = r_bf;
    w_layer_nxt = r_layer;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The done-pulse cycle still belongs to the finished transform.
        if (io_sched.start && !r_done) begin
          w_state_nxt = ST_ISSUE;
          w_sel_nxt   = io_sched.mode;
          w_layer_nxt = 3'd0;
          w_bf_nxt    = 7'd0;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!io_sched.stall) begin
          w_issue = 1'b1;
          if (r_bf == LAST_BF) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_bf_nxt = r_bf + 7'd1;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          if (r_layer == LAST_LAYER) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_layer_nxt = r_layer + 3'd1;
            w_bf_nxt    = 7'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Butterfly geometry: len = 2^lg, g = bf >> lg, o = bf & (len-1), shifts only.
  always_comb begin
    if (r_sel) begin
      w_lg = r_layer + 3'd1;
    end else begin
      w_lg = 3'd7 - r_layer;
    end
    w_len = 8'd1 << w_lg;
    w_g   = {1'b0, r_bf} >> w_lg;
    w_o   = {1'b0, r_bf} & (w_len - 8'd1);
    w_up  = (w_g << ({1'b0, w_lg} + 4'd1)) | w_o;
    w_dn  = w_up + w_len;
    if (r_sel) begin
      w_zeta = 7'((8'd1 << (4'd8 - {1'b0, w_lg})) - 8'd1 - w_g);
    end else begin
      w_zeta = 7'((8'd1 << (3'd7 - w_lg)) + w_g);
    end
  end

  // Counters, latched mode and registered issue outputs; address fields hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bf      <= 7'd0;
      r_layer   <= 3'd0;
      r_cnt     <= 8'd0;
      r_sel     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_v       <= 1'b0;
      r_last    <= 1'b0;
      r_fin     <= 1'b0;
      r_addr_up <= 8'd0;
      r_addr_dn <= 8'd0;
      r_zeta    <= 7'd0;
      r_layer_o <= 3'd0;
    end else begin
      r_bf    <= w_bf_nxt;
      r_layer <= w_layer_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= (r_state != ST_IDLE);
      r_done  <= (r_state == ST_FIN);
      r_v     <= w_issue;
      r_last  <= w_issue && (r_layer == LAST_LAYER);
      r_fin   <= w_issue && (r_layer == LAST_LAYER) && (r_bf == LAST_BF);
      if (w_issue) begin
        r_addr_up <= w_up;
        r_addr_dn <= w_dn;
        r_zeta    <= w_zeta;
        r_layer_o <= r_layer;
      end
    end
  end

  assign io_sched.busy     = r_busy;
  assign io_sched.done     = r_done;
  assign io_sched.o_v      = r_v;
  assign io_sched.o_last   = r_last;
  assign io_sched.o_done   = r_fin;
  assign io_sched.o_sel    = r_sel;
  assign io_sched.addr_up  = r_addr_up;
  assign io_sched.addr_dn  = r_addr_dn;
  assign io_sched.zeta_idx = r_zeta;
  assign io_sched.layer    = r_layer_o;

endmodule

// File: tb/tb_ntt_sched.sv
// Directed bench for ntt_sched: timing landmarks, INTT geometry, stall, full
// scoreboarded runs in both modes, ignored starts and mid-transform reset.
module tb_ntt_sched;
  localparam int DRAIN_P = 8;
  localparam int NBF     = 896;

  logic clk;
  logic rst;
  ntt_sched_if intf();

  ntt_sched #(.DRAIN(DRAIN_P)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_sched (intf.master)
  );

  int n_vec = 0;
  int n_err = 0;
  int edge_no = 0;
  int exp_up[NBF];
  int exp_dn[NBF];
  int exp_z[NBF];
  int exp_l[NBF];
  int cov[7][256];

  logic [31:0] all_out;
  assign all_out = {intf.busy, intf.done, intf.o_v, intf.o_last, intf.o_done, intf.o_sel,
                    intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    edge_no++;
    #1;
  endtask

  task automatic wait_until(input int t);
    while (edge_no < t) tick();
  endtask

  task automatic do_reset();
    intf.start = 1'b0;
    intf.mode  = 1'b0;
    intf.stall = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_xfer(input logic m, output int s);
    intf.mode  = m;
    intf.start = 1'b1;
    tick();
    s = edge_no;
    intf.start = 1'b0;
    intf.mode  = ~m;
  endtask

  // Textbook Kyber loop: groups of len butterflies, one zeta per group.
  task automatic build_expected(input logic m);
    int idx;
    int k;
    int len;
    idx = 0;
    k = m ? 127 : 1;
    for (int l = 0; l < 7; l++) begin
      len = m ? (2 << l) : (128 >> l);
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          exp_up[idx] = j;
          exp_dn[idx] = j + len;
          exp_z[idx]  = k;
          exp_l[idx]  = l;
          idx++;
        end
        k = m ? k - 1 : k + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    intf.start = 1'b1;
    intf.mode  = 1'b1;
    intf.stall = 1'b0;
    tick();
    tick();
    n_vec++;
    if (all_out !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", all_out, 32'd0);
    end
    intf.start = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({intf.busy, intf.o_v, intf.o_sel} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle: got %b expected %b", {intf.busy, intf.o_v, intf.o_sel}, 3'b000);
    end
  endtask

  task automatic test_ntt_timing();
    int s;
    int gap_v;
    bit got;
    do_reset();
    start_xfer(1'b0, s);
    wait_until(s + 1);
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.o_sel, intf.busy, intf.layer}
        !== {1'b1, 8'd0, 8'd128, 7'd1, 1'b0, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL ntt_first: got v=%b %0d/%0d z=%0d sel=%b busy=%b L=%0d expected 1 0/128 z=1 sel=0 busy=1 L=0",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.o_sel, intf.busy, intf.layer);
    end
    wait_until(s + 128);
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer}
        !== {1'b1, 8'd127, 8'd255, 7'd1, 3'd0}) begin
      n_err++;
      $display("FAIL ntt_issue128: got v=%b %0d/%0d z=%0d L=%0d expected 1 127/255 z=1 L=0",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer);
    end
    gap_v = 0;
    for (int i = 0; i < DRAIN_P; i++) begin
      tick();
      if (intf.o_v) gap_v++;
    end
    n_vec++;
    if (gap_v !== 0) begin
      n_err++;
      $display("FAIL ntt_drain_gap: got %0d valid cycles expected 0", gap_v);
    end
    wait_until(s + 137);
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer}
        !== {1'b1, 8'd0, 8'd64, 7'd2, 3'd1}) begin
      n_err++;
      $display("FAIL ntt_layer1_bf0: got v=%b %0d/%0d z=%0d L=%0d expected 1 0/64 z=2 L=1",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer);
    end
    wait_until(s + 201);
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer}
        !== {1'b1, 8'd128, 8'd192, 7'd3, 3'd1}) begin
      n_err++;
      $display("FAIL ntt_layer1_bf64: got v=%b %0d/%0d z=%0d L=%0d expected 1 128/192 z=3 L=1",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer);
    end
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      tick();
      if (intf.done) got = 1'b1;
    end
    n_vec++;
    if (!got || edge_no != s + 897 + 7 * DRAIN_P) begin
      n_err++;
      $display("FAIL ntt_done_time: got offset %0d (seen=%0d) expected %0d",
               edge_no - s, got, 897 + 7 * DRAIN_P);
    end
    n_vec++;
    if (intf.busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_in_done: got %b expected 1", intf.busy);
    end
    // start held through the done cycle (ignored) and the cycle after (accepted)
    intf.start = 1'b1;
    intf.mode  = 1'b1;
    tick();
    n_vec++;
    if ({intf.busy, intf.done, intf.o_sel} !== 3'b000) begin
      n_err++;
      $display("FAIL after_done: got busy/done/sel %b expected 000", {intf.busy, intf.done, intf.o_sel});
    end
    tick();
    intf.start = 1'b0;
    intf.mode  = 1'b0;
    n_vec++;
    if (intf.o_v !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done_ignored: got o_v %b expected 0", intf.o_v);
    end
    tick();
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.o_sel}
        !== {1'b1, 8'd0, 8'd2, 7'd127, 1'b1}) begin
      n_err++;
      $display("FAIL start_after_done: got v=%b %0d/%0d z=%0d sel=%b expected 1 0/2 z=127 sel=1",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.o_sel);
    end
  endtask

  task automatic test_intt();
    int s;
    logic [22:0] exp_v[3];
    exp_v[0] = {8'd0, 8'd2, 7'd127};
    exp_v[1] = {8'd1, 8'd3, 7'd127};
    exp_v[2] = {8'd4, 8'd6, 7'd126};
    do_reset();
    start_xfer(1'b1, s);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({intf.o_v, intf.o_sel, intf.layer, intf.addr_up, intf.addr_dn, intf.zeta_idx}
          !== {1'b1, 1'b1, 3'd0, exp_v[i]}) begin
        n_err++;
        $display("FAIL intt_layer0_bf%0d: got v=%b sel=%b %0d/%0d z=%0d expected %0d/%0d z=%0d",
                 i, intf.o_v, intf.o_sel, intf.addr_up, intf.addr_dn, intf.zeta_idx,
                 exp_v[i][22:15], exp_v[i][14:7], exp_v[i][6:0]);
      end
    end
    wait_until(s + 1 + 6 * (128 + DRAIN_P));
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer, intf.o_last, intf.o_done}
        !== {1'b1, 8'd0, 8'd128, 7'd1, 3'd6, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL intt_layer6_bf0: got v=%b %0d/%0d z=%0d L=%0d last=%b fin=%b expected 1 0/128 z=1 L=6 last=1 fin=0",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer, intf.o_last, intf.o_done);
    end
    wait_until(s + 128 + 6 * (128 + DRAIN_P));
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.o_last, intf.o_done}
        !== {1'b1, 8'd127, 8'd255, 7'd1, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL intt_final_issue: got v=%b %0d/%0d z=%0d last=%b fin=%b expected 1 127/255 z=1 last=1 fin=1",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.o_last, intf.o_done);
    end
  endtask

  task automatic test_stall();
    int s;
    bit got;
    do_reset();
    start_xfer(1'b0, s);
    wait_until(s + 1 + 2 * (128 + DRAIN_P) + 40);
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer}
        !== {1'b1, 8'd72, 8'd104, 7'd5, 3'd2}) begin
      n_err++;
      $display("FAIL stall_pre: got v=%b %0d/%0d z=%0d L=%0d expected 1 72/104 z=5 L=2",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer);
    end
    intf.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer}
          !== {1'b0, 8'd72, 8'd104, 7'd5, 3'd2}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b %0d/%0d z=%0d L=%0d expected 0 72/104 z=5 L=2",
                 i, intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer);
      end
    end
    intf.stall = 1'b0;
    tick();
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer}
        !== {1'b1, 8'd73, 8'd105, 7'd5, 3'd2}) begin
      n_err++;
      $display("FAIL stall_resume: got v=%b %0d/%0d z=%0d L=%0d expected 1 73/105 z=5 L=2",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer);
    end
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      tick();
      if (intf.done) got = 1'b1;
    end
    n_vec++;
    if (!got || edge_no != s + 897 + 7 * DRAIN_P + 3) begin
      n_err++;
      $display("FAIL stall_done_time: got offset %0d (seen=%0d) expected %0d",
               edge_no - s, got, 897 + 7 * DRAIN_P + 3);
    end
  endtask

  task automatic test_full_run(input logic m, input bit pulse);
    int s;
    int idx;
    int n_last;
    int n_fin;
    int bad;
    bit got;
    logic [27:0] act;
    logic [27:0] exp;
    build_expected(m);
    for (int l = 0; l < 7; l++) begin
      for (int a = 0; a < 256; a++) cov[l][a] = 0;
    end
    do_reset();
    start_xfer(m, s);
    idx = 0;
    n_last = 0;
    n_fin = 0;
    got = 1'b0;
    for (int c = 0; c < 1200 && !got; c++) begin
      if (pulse && edge_no == s + 300) begin
        intf.start = 1'b1;
        intf.mode  = ~m;
      end
      if (pulse && edge_no == s + 303) intf.start = 1'b0;
      tick();
      if (intf.o_v) begin
        if (idx < NBF) begin
          act = {intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer, intf.o_sel, intf.o_last, intf.o_done};
          exp = {8'(exp_up[idx]), 8'(exp_dn[idx]), 7'(exp_z[idx]), 3'(exp_l[idx]), m,
                 exp_l[idx] == 6, idx == NBF - 1};
          n_vec++;
          if (act !== exp) begin
            n_err++;
            $display("FAIL full_run m=%0d issue %0d: got %h expected %h", m, idx, act, exp);
          end
        end
        if (intf.layer < 3'd7) begin
          cov[intf.layer][intf.addr_up]++;
          cov[intf.layer][intf.addr_dn]++;
        end
        if (intf.o_last) n_last++;
        if (intf.o_done) n_fin++;
        idx++;
      end
      if (intf.done) got = 1'b1;
    end
    n_vec++;
    if ({idx, n_last, n_fin} !== {32'(NBF), 32'd128, 32'd1} || !got) begin
      n_err++;
      $display("FAIL full_run_counts m=%0d: got v=%0d last=%0d fin=%0d done=%0d expected 896 128 1 1",
               m, idx, n_last, n_fin, got);
    end
    for (int l = 0; l < 7; l++) begin
      bad = 0;
      for (int a = 0; a < 256; a++) begin
        if (cov[l][a] != 1) bad++;
      end
      n_vec++;
      if (bad !== 0) begin
        n_err++;
        $display("FAIL full_run_cover m=%0d layer %0d: got %0d indices not touched once expected 0", m, l, bad);
      end
    end
  endtask

  task automatic test_rst_mid();
    int s;
    int act_cnt;
    do_reset();
    start_xfer(1'b0, s);
    wait_until(s + 450);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (all_out !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %h expected %h", all_out, 32'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    act_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (intf.done || intf.o_v || intf.busy) act_cnt++;
    end
    n_vec++;
    if (act_cnt !== 0) begin
      n_err++;
      $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", act_cnt);
    end
    start_xfer(1'b0, s);
    wait_until(s + 2);
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer}
        !== {1'b1, 8'd1, 8'd129, 7'd1, 3'd0}) begin
      n_err++;
      $display("FAIL rst_restart_bf1: got v=%b %0d/%0d z=%0d L=%0d expected 1 1/129 z=1 L=0",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer);
    end
    wait_until(s + 137);
    n_vec++;
    if ({intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer}
        !== {1'b1, 8'd0, 8'd64, 7'd2, 3'd1}) begin
      n_err++;
      $display("FAIL rst_restart_layer1: got v=%b %0d/%0d z=%0d L=%0d expected 1 0/64 z=2 L=1",
               intf.o_v, intf.addr_up, intf.addr_dn, intf.zeta_idx, intf.layer);
    end
  endtask

  initial begin
    rst = 1'b1;
    intf.start = 1'b0;
    intf.mode  = 1'b0;
    intf.stall = 1'b0;
    test_reset();
    test_ntt_timing();
    test_intt();
    test_stall();
    test_full_run(1'b0, 1'b1);
    test_full_run(1'b1, 1'b1);
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ntt_sched.md
Name: ntt_sched

Overview:
Sequencer that drives the butterfly pipeline (fetch → VA → EX → WR) for a full 256-point Kyber NTT or INTT, one butterfly per cycle. It generates the up/down coefficient addresses, the zeta index, the mode select, and the last-stage and done flags for every butterfly. It inserts a drain gap between layers so that reads of layer L+1 never overtake the writes of layer L. It reports transform completion to the top-level controller.

Parameters:
DRAIN, 8, number of idle issue cycles after each layer (pipeline depth from issue to write-back); legal range 1..255
N, 256, number of coefficients; fixed, not overridable

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  request a transform; sampled only in IDLE
mode  in  1  0 = NTT, 1 = INTT; latched on accepted start
stall  in  1  holds issue for this cycle (downstream backpressure)
busy  out  1  transform in progress
done  out  1  one-cycle pulse after the final layer has drained
o_v  out  1  butterfly issue valid
o_last  out  1  issued butterfly belongs to layer 6 (qualified by o_v)
o_done  out  1  issued butterfly is the final one of the transform (qualified by o_v)
o_sel  out  1  latched mode, 0 = NTT, 1 = INTT
addr_up  out  8  index j of the upper operand
addr_dn  out  8  index j+len of the lower operand
zeta_idx  out  7  twiddle ROM index (1..127)
layer  out  3  current layer, 0..6

Behaviour:
- All outputs are registered. Reset values: every output is 0. rst asserted at any time forces state IDLE immediately, clears all counters, and abandons any transform in flight with no done pulse.
- States:
  - IDLE: start=1 → latch mode into o_sel, set layer=0, bf=0, go to ISSUE.
  - ISSUE → DRAIN after bf=127 issues.
  - DRAIN: count DRAIN cycles. On expiry: if layer=6 go to FIN; otherwise increment layer, set bf=0, go to ISSUE.
  - FIN: lasts one cycle, then go to IDLE.
- start is ignored outside IDLE. mode is ignored except on an accepted start.
- len per layer:
  - NTT: len = 128 >> layer.
  - INTT: len = 2 << layer.
- Per butterfly bf (0..127) within a layer, using shifts only (no dividers):
  - g = bf / len, o = bf mod len.
  - addr_up = 2·len·g + o; addr_dn = addr_up + len.
  - zeta_idx: NTT = 128/len + g; INTT = 256/len − 1 − g.
- ISSUE with stall=0: o_v=1, outputs carry the current bf, then bf increments.
- ISSUE with stall=1: o_v=0, address/zeta/flags hold their previous values, bf does not advance, nothing is skipped or duplicated.
- stall is ignored in DRAIN and FIN; the drain count does not pause.
- o_last = o_v and (layer=6). o_done = o_v and (layer=6) and (bf=127).
- Timing without stalls, with the accepted start at edge S:
  - busy=1 from S+1 through the done cycle.
  - Layer i issues during cycles S+1+i·(128+DRAIN) through +127.
  - done=1 at S+897+7·DRAIN.
  - busy=0 in the following cycle.
  - Each stall cycle delays everything after it by one cycle.
- A start in the done/FIN cycle is ignored. A start in the cycle after done is accepted.
- o_v is never asserted in IDLE, DRAIN or FIN.

Test Plan:
- NTT, DRAIN=8, start at S, no stall:
  - First issue at S+1: 0/128, zeta 1, o_sel=0.
  - Issue 128: 127/255, zeta 1.
  - o_v=0 for S+129..S+136.
  - Layer 1 at S+137: 0/64, zeta 2. Its bf 64: 128/192, zeta 3.
  - done at S+953.
- INTT:
  - Layer 0 bf0: 0/2, zeta 127, o_sel=1. bf1: 1/3, zeta 127. bf2: 4/6, zeta 126.
  - Layer 6 bf0: 0/128, zeta 1, o_last=1.
- Stall held 3 cycles in the middle of layer 2:
  - o_v low for 3 cycles, address and zeta frozen.
  - Sequence resumes at the next bf without a gap in addresses.
  - done is delayed by exactly 3 cycles.
- Full run, both modes, scoreboard against a reference loop:
  - Exactly 896 o_v, 128 o_last, 1 o_done (on the last issue).
  - Each layer touches every index 0..255 exactly once.
- start pulsed with mode flipped during busy → ignored; the sequence and o_sel are unchanged.
- rst asserted in the middle of layer 3:
  - All outputs are 0 at once and no done pulse follows.
  - A new start yields a correct sequence from layer 0.
